// File: rtl/dmem_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | dmem_arbiter : two-master arbiter for a single-port data memory,     |
// | round-robin with a burst cap; DMEM_ARB_FIXED_PRIO_EN gives m0 fixed  |
// | priority.                                                   Rev 1.0  |
// +----------------------------------------------------------------------+
module dmem_arbiter #(
   parameter int AW        = 32,
   parameter int DW        = 32,
   parameter int MAX_BURST = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              m0_req,
   input  logic [AW-1:0]     m0_addr,
   input  logic [DW-1:0]     m0_wdata,
   input  logic [DW/8-1:0]   m0_we,
   output logic              m0_gnt,
   output logic [DW-1:0]     m0_rdata,
   input  logic              m1_req,
   input  logic [AW-1:0]     m1_addr,
   input  logic [DW-1:0]     m1_wdata,
   input  logic [DW/8-1:0]   m1_we,
   output logic              m1_gnt,
   output logic [DW-1:0]     m1_rdata,
   output logic [AW-1:0]     daddr,
   output logic [DW-1:0]     dwdata,
   output logic [DW/8-1:0]   dwe,
   input  logic [DW-1:0]     drdata
);
   localparam int CW = $clog2(MAX_BURST + 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      OWN0 = 2'd1,
      OWN1 = 2'd2
   } state_t;

   state_t        state, state_nxt;
   logic [CW-1:0] cnt, cnt_nxt;
   logic [CW:0]   cnt_inc;
   logic [CW-1:0] cnt_sat;
   logic          burst_done;
   logic          ready;
   logic          tie_pick1;

`ifdef DMEM_ARB_FIXED_PRIO_EN
   localparam logic PREEMPT_M0 = 1'b0;
   assign tie_pick1 = 1'b0;
`else
   localparam logic PREEMPT_M0 = 1'b1;
   logic last;

   // last-served master; reset value 1 lets m0 win the first tie
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)      last <= 1'b1;
      else if (m0_gnt) last <= 1'b0;
      else if (m1_gnt) last <= 1'b1;
   end

   assign tie_pick1 = ~last;
`endif

   assign cnt_inc    = {1'b0, cnt} + 1'b1;
   assign burst_done = (cnt_inc >= (CW+1)'(MAX_BURST));
   assign cnt_sat    = burst_done ? CW'(MAX_BURST) : cnt_inc[CW-1:0];

   // ready holds IDLE for the first edge after reset release
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
         cnt   <= '0;
         ready <= 1'b0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         ready <= 1'b1;
      end
   end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      case (state)
         IDLE: begin
            cnt_nxt = '0;
            if (ready) begin
               if (m0_req && m1_req) state_nxt = tie_pick1 ? OWN1 : OWN0;
               else if (m0_req)      state_nxt = OWN0;
               else if (m1_req)      state_nxt = OWN1;
            end
         end
         OWN0: begin
            if (m0_req) begin
               cnt_nxt = cnt_sat;
               if (burst_done && m1_req && PREEMPT_M0) begin
                  state_nxt = OWN1;
                  cnt_nxt   = '0;
               end
            end else begin
               cnt_nxt   = '0;
               state_nxt = m1_req ? OWN1 : IDLE;
            end
         end
         OWN1: begin
            if (m1_req) begin
               cnt_nxt = cnt_sat;
               if (burst_done && m0_req) begin
                  state_nxt = OWN0;
                  cnt_nxt   = '0;
               end
            end else begin
               cnt_nxt   = '0;
               state_nxt = m0_req ? OWN0 : IDLE;
            end
         end
         default: begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
         end
      endcase
   end

   assign m0_gnt   = (state == OWN0) && m0_req;
   assign m1_gnt   = (state == OWN1) && m1_req;
   assign m0_rdata = m0_gnt ? drdata : '0;
   assign m1_rdata = m1_gnt ? drdata : '0;

   // the owner keeps driving address/data even without a beat; only dwe is gated
   always_comb begin
      daddr  = '0;
      dwdata = '0;
      dwe    = '0;
      if (state == OWN0) begin
         daddr  = m0_addr;
         dwdata = m0_wdata;
         if (m0_req) dwe = m0_we;
      end else if (state == OWN1) begin
         daddr  = m1_addr;
         dwdata = m1_wdata;
         if (m1_req) dwe = m1_we;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// tb_dmem_arbiter : directed and randomized checks of dmem_arbiter against a
// transaction-level model (owner, beat count, last served, shadow memory).
module tb_dmem_arbiter;
   localparam int AW   = 32;
   localparam int DW   = 32;
   localparam int MAXB = 4;
`ifdef DMEM_ARB_FIXED_PRIO_EN
   localparam bit FIXED = 1'b1;
`else
   localparam bit FIXED = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          reset;
   logic          m0_req, m1_req;
   logic [AW-1:0] m0_addr, m1_addr;
   logic [DW-1:0] m0_wdata, m1_wdata;
   logic [3:0]    m0_we, m1_we;
   logic          m0_gnt, m1_gnt;
   logic [DW-1:0] m0_rdata, m1_rdata;
   logic [AW-1:0] daddr;
   logic [DW-1:0] dwdata;
   logic [3:0]    dwe;
   logic [DW-1:0] drdata;

   dmem_arbiter #(.AW(AW), .DW(DW), .MAX_BURST(MAXB)) dut (
      .clk(clk), .reset(reset),
      .m0_req(m0_req), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_we(m0_we),
      .m0_gnt(m0_gnt), .m0_rdata(m0_rdata),
      .m1_req(m1_req), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_we(m1_we),
      .m1_gnt(m1_gnt), .m1_rdata(m1_rdata),
      .daddr(daddr), .dwdata(dwdata), .dwe(dwe), .drdata(drdata)
   );

   always #5 clk = ~clk;

   // memory attached to the DUT; pre_en preloads it while the arbiter is in reset
   logic [31:0] dmem [16];
   logic        pre_en;
   logic [3:0]  pre_idx;
   logic [31:0] pre_val;
   assign drdata = dmem[daddr[5:2]];
   always @(posedge clk) begin
      if (pre_en) dmem[pre_idx] <= pre_val;
      else for (int b = 0; b < 4; b++)
         if (dwe[b]) dmem[daddr[5:2]][8*b +: 8] <= dwdata[8*b +: 8];
   end

   logic [31:0] ref_mem [16];
   int          own, beats, last;
   bit          ready;
   int          n_tests, n_fail;
   logic        obs_g0, obs_g1;
   logic [31:0] obs_rd1;

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                         input logic [3:0] we);
      logic [31:0] r;
      r = old;
      for (int b = 0; b < 4; b++) if (we[b]) r[8*b +: 8] = d[8*b +: 8];
      return r;
   endfunction

   task automatic model_reset();
      own = -1; beats = 0; last = 1; ready = 1'b0;
   endtask

   task automatic set_m0(input bit r, input logic [31:0] a, input logic [31:0] d, input logic [3:0] w);
      m0_req = r; m0_addr = a; m0_wdata = d; m0_we = w;
   endtask

   task automatic set_m1(input bit r, input logic [31:0] a, input logic [31:0] d, input logic [3:0] w);
      m1_req = r; m1_addr = a; m1_wdata = d; m1_we = w;
   endtask

   task automatic check_mem(input string tag);
      for (int i = 0; i < 16; i++) check_val(tag, dmem[i], ref_mem[i]);
   endtask

   // called at a falling edge with inputs applied: compare, advance model, wait next falling edge
   task automatic step(input string tag);
      bit          g0, g1;
      bit          rq [2];
      logic [31:0] ea, ed, er0, er1;
      logic [3:0]  ew;
      int          x, o;
      #1;
      g0 = (own == 0) && m0_req;
      g1 = (own == 1) && m1_req;
      ea = '0; ed = '0; ew = '0;
      if (own == 0) begin ea = m0_addr; ed = m0_wdata; ew = g0 ? m0_we : 4'h0; end
      else if (own == 1) begin ea = m1_addr; ed = m1_wdata; ew = g1 ? m1_we : 4'h0; end
      er0 = g0 ? ref_mem[m0_addr[5:2]] : 32'h0;
      er1 = g1 ? ref_mem[m1_addr[5:2]] : 32'h0;
      check_val({tag, " gnt"}, {m1_gnt, m0_gnt}, {g1, g0});
      check_val({tag, " daddr"}, daddr, ea);
      check_val({tag, " dwdata"}, dwdata, ed);
      check_val({tag, " dwe"}, dwe, ew);
      check_val({tag, " rdata"}, {m1_rdata, m0_rdata}, {er1, er0});
      obs_g0 = m0_gnt; obs_g1 = m1_gnt; obs_rd1 = m1_rdata;

      if (g0) ref_mem[m0_addr[5:2]] = merge(ref_mem[m0_addr[5:2]], m0_wdata, m0_we);
      if (g1) ref_mem[m1_addr[5:2]] = merge(ref_mem[m1_addr[5:2]], m1_wdata, m1_we);
      rq[0] = m0_req; rq[1] = m1_req;
      if (!ready) begin
         ready = 1'b1;
      end else if (own < 0) begin
         beats = 0;
         if (rq[0] && rq[1]) begin
            if (FIXED) own = 0;
            else       own = (last == 1) ? 0 : 1;
         end else if (rq[0]) own = 0;
         else if (rq[1])     own = 1;
      end else begin
         x = own; o = 1 - x;
         if (rq[x]) begin
            last  = x;
            beats = (beats + 1 > MAXB) ? MAXB : beats + 1;
            if (rq[o] && beats >= MAXB && (!FIXED || x == 1)) begin
               own = o; beats = 0;
            end
         end else begin
            own = rq[o] ? o : -1; beats = 0;
         end
      end
      @(negedge clk);
   endtask

   int  g0cnt, first1, last0;
   bit  m1_done;

   initial begin
      n_tests = 0; n_fail = 0;
      pre_en = 1'b0; pre_idx = '0; pre_val = '0;
      obs_g0 = 1'b0; obs_g1 = 1'b0; obs_rd1 = '0;
      set_m0(1'b1, 32'h0, 32'hCAFE_F00D, 4'hF);
      set_m1(1'b1, 32'h10, 32'h0, 4'h0);
      reset = 1'b0;
      model_reset();

      // requests held during reset must not be granted or written
      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         pre_en  = 1'b1;
         pre_idx = 4'(i);
         pre_val = (i == 4) ? 32'hDEADBEEF : (i == 2) ? 32'h1122_3344 : $urandom;
         ref_mem[i] = pre_val;
         #1;
         check_val("rst gnt", {m1_gnt, m0_gnt}, 2'b00);
         check_val("rst dwe", dwe, 4'h0);
         check_val("rst daddr", daddr, 32'h0);
         check_val("rst dwdata", dwdata, 32'h0);
         check_val("rst rdata", {m1_rdata, m0_rdata}, 64'h0);
      end
      @(negedge clk);
      pre_en = 1'b0;
      check_mem("rst mem");
      reset = 1'b1;

      // tie straight after reset: m0 first, no grant before the second edge
      step("rel0");
      step("rel1");
      step("rel2");
      check_val("tie m0 first", {obs_g1, obs_g0}, 2'b01);
      set_m0(1'b0, 32'h0, 32'h0, 4'h0);
      step("tie_hand");
      step("tie_m1");
      check_val("tie m1 second", obs_g1, 1'b1);
      set_m1(1'b0, 32'h0, 32'h0, 4'h0);
      step("drain0");

      // single read from IDLE
      set_m1(1'b1, 32'h10, 32'h0, 4'h0);
      step("rd_req");
      check_val("rd latency", obs_g1, 1'b0);
      step("rd_beat");
      check_val("rd gnt", obs_g1, 1'b1);
      check_val("rd data", obs_rd1, 32'hDEADBEEF);
      set_m1(1'b0, 32'h0, 32'h0, 4'h0);
      step("drain1");

      // byte-lane write
      set_m0(1'b1, 32'h8, 32'h0000_AB00, 4'b0010);
      step("wr_req");
      step("wr_beat");
      set_m0(1'b0, 32'h0, 32'h0, 4'h0);
      step("wr_done");
      check_val("byte write", dmem[2], 32'h1122_AB44);

      // second tie: m0 was served last, so m1 wins under round-robin
      set_m0(1'b1, 32'h8, 32'h0, 4'h0);
      set_m1(1'b1, 32'h10, 32'h0, 4'h0);
      step("rr_req");
      step("rr_beat");
`ifdef DMEM_ARB_FIXED_PRIO_EN
      check_val("fixed tie m0", {obs_g1, obs_g0}, 2'b01);
`else
      check_val("rr tie m1", {obs_g1, obs_g0}, 2'b10);
`endif
      if (obs_g1) set_m1(1'b0, 32'h0, 32'h0, 4'h0);
      if (obs_g0) set_m0(1'b0, 32'h0, 32'h0, 4'h0);
      step("rr_hand");
      step("rr_other");
      set_m0(1'b0, 32'h0, 32'h0, 4'h0);
      set_m1(1'b0, 32'h0, 32'h0, 4'h0);
      step("drain2");
      step("drain3");

      // burst cap: m0 requests 10 cycles, m1 joins from cycle 2
      g0cnt = 0; first1 = -1; last0 = -1; m1_done = 1'b0;
      for (int c = 0; c < 14; c++) begin
         set_m0(c < 10, 32'h20, 32'h0, 4'h0);
         set_m1((c >= 2) && !m1_done, 32'h24, 32'h0, 4'h0);
         step("burst");
         if (obs_g1 && first1 < 0) first1 = c;
         if (obs_g0 && first1 < 0) begin g0cnt++; last0 = c; end
         if (obs_g1) m1_done = 1'b1;
      end
`ifdef DMEM_ARB_FIXED_PRIO_EN
      check_val("fixed m1 held off", first1 >= 10, 1'b1);
`else
      check_val("burst m0 beats", g0cnt, MAXB);
      check_val("burst no gap", first1, last0 + 1);
`endif
      set_m0(1'b0, 32'h0, 32'h0, 4'h0);
      set_m1(1'b0, 32'h0, 32'h0, 4'h0);
      step("drain4");
      step("drain5");

      // randomized traffic; a pending request is held until granted
      for (int c = 0; c < 600; c++) begin
         if (!m0_req || obs_g0)
            set_m0($urandom_range(0, 2) != 0, {26'h0, 4'($urandom), 2'b00}, $urandom,
                   ($urandom_range(0, 1) != 0) ? 4'($urandom) : 4'h0);
         if (!m1_req || obs_g1)
            set_m1($urandom_range(0, 3) != 0, {26'h0, 4'($urandom), 2'b00}, $urandom,
                   ($urandom_range(0, 1) != 0) ? 4'($urandom) : 4'h0);
         step("rand");
      end
      set_m0(1'b0, 32'h0, 32'h0, 4'h0);
      set_m1(1'b0, 32'h0, 32'h0, 4'h0);
      step("drain6");
      step("drain7");
      check_mem("rand mem");

      // reset asserted in the middle of a write beat
      set_m0(1'b1, 32'h30, 32'h5A5A_5A5A, 4'hF);
      step("mr_req");
      #1;
      check_val("mr pre gnt", m0_gnt, 1'b1);
      reset = 1'b0;
      #1;
      check_val("mr gnt", {m1_gnt, m0_gnt}, 2'b00);
      check_val("mr dwe", dwe, 4'h0);
      @(negedge clk);
      @(negedge clk);
      reset = 1'b1;
      model_reset();
      set_m0(1'b0, 32'h0, 32'h0, 4'h0);
      check_val("mr no commit", dmem[12], ref_mem[12]);
      step("post0");
      step("post1");
      check_mem("final mem");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 The block SHALL have parameter AW, default 32, address width.
REQ-002 The block SHALL have parameter DW, default 32, data width (byte lanes = DW/8).
REQ-003 The block SHALL have parameter MAX_BURST, default 4, max consecutive beats per owner while the other master waits.
REQ-004 Ports SHALL be: clk  in  1  clock, all state updates on rising edge.
REQ-005 reset  in  1  asynchronous, active-low reset (0 = reset asserted).
REQ-006 m0_req, m1_req  in  1  master access request.
REQ-007 m0_addr, m1_addr  in  AW  byte address.
REQ-008 m0_wdata, m1_wdata  in  DW  write data.
REQ-009 m0_we, m1_we  in  DW/8  byte-lane write enables; all-zero = read.
REQ-010 m0_gnt, m1_gnt  out  1  beat performed this cycle.
REQ-011 m0_rdata, m1_rdata  out  DW  read data, valid when gnt high and we all-zero.
REQ-012 daddr  out  AW; dwdata  out  DW; dwe  out  DW/8; drdata  in  DW  -- dmem port (combinational read, write on rising edge).

Function
REQ-013 FSM states SHALL be IDLE, OWN0, OWN1, held in a registered state, plus a beat counter (0..MAX_BURST) and a last-served pointer.
REQ-014 mX_gnt SHALL equal (state==OWNX) && mX_req, combinationally; never both high.
REQ-015 When mX_gnt=1: daddr=mX_addr, dwdata=mX_wdata, dwe=mX_we; write commits at the closing rising edge.
REQ-016 When no gnt is high: dwe SHALL be 0; daddr and dwdata SHALL be 0 in IDLE, and the owner's addr/wdata in OWNX.
REQ-017 mX_rdata SHALL equal drdata when mX_gnt=1, else 0.
REQ-018 IDLE: no req -> stay; one req -> OWN of that master; both -> OWN of the master not last served (round-robin). Grant latency from IDLE = 1 cycle.
REQ-019 OWNX, mX_req=1: beat performed, counter increments (saturates at MAX_BURST); last-served := X.
REQ-020 OWNX, counter reaches MAX_BURST on this beat and other req=1 -> OWN(other), counter := 0.
REQ-021 OWNX, mX_req=0: other req=1 -> OWN(other); else -> IDLE; counter := 0.
REQ-022 OWNX, mX_req=1, other req=0: stay in OWNX indefinitely (no limit when uncontended).
REQ-023 Masters SHALL hold req, addr, wdata, we stable until gnt; the block does not latch requests.
REQ-024 Requester change mid-burst (other asserts req): current owner finishes to MAX_BURST beats total, then hands over, with no idle cycle in between.

Reset
REQ-025 While reset=0 (asynchronously): state=IDLE, counter=0, last-served=1 (so m0 wins the first tie).
REQ-026 Outputs during reset: m0_gnt=m1_gnt=0, dwe=0, daddr=0, dwdata=0, rdata=0.
REQ-027 Reset asserted mid-beat SHALL force dwe=0 immediately; the pending write SHALL not commit.
REQ-028 After release, first grant SHALL appear no earlier than the second rising edge after reset deasserts.

Configuration
REQ-029 Macro DMEM_ARB_FIXED_PRIO_EN: if defined, ties in IDLE and REQ-020 handover SHALL favour m0 (m1 preempted by waiting m0 after MAX_BURST beats; m0 never preempted by m1); last-served is unused.
REQ-030 Without DMEM_ARB_FIXED_PRIO_EN: round-robin per REQ-018/REQ-020.

Verification
REQ-031 Reset: reset=0 with m0_req=1, m0_we=4'hF -> gnt=0, dwe=0, memory unchanged.
REQ-032 Single read: m1_req, m1_addr=0x10, dmem[4]=0xDEADBEEF -> m1_gnt one cycle after request, m1_rdata=0xDEADBEEF, dwe=0.
REQ-033 Tie: both req from IDLE after reset -> OWN0 first; both re-request after release -> OWN1 next (round-robin).
REQ-034 Burst limit: m0 holds req 10 cycles, m1 req from cycle 2 -> m0 gets exactly 4 gnt cycles, m1_gnt next cycle, no gap.
REQ-035 Byte write: m0 writes addr 0x8, we=4'b0010, wdata=0x0000AB00 over 0x11223344 -> dmem word 0x1122AB44.
REQ-036 With DMEM_ARB_FIXED_PRIO_EN: both continuously requesting -> m0 never loses grant; m1_gnt stays 0.
